// File: rtl/timer_pkg.sv
// Shared types and default widths for the timer scheduler slice.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned PW_DEF = 16;
  localparam int unsigned TW_DEF = 16;

endpackage

// File: rtl/timer_engine.sv
// Prescaler/top counter pair: pc rolls over every P cycles, tc counts rollovers up to T.
module timer_engine
  import timer_pkg::*;
#(
  parameter int unsigned PW = PW_DEF,
  parameter int unsigned TW = TW_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  input  logic [PW-1:0] P,
  input  logic [TW-1:0] T,
  output logic          tick,
  output logic          expire
);

  logic [PW-1:0] pc;
  logic [TW-1:0] tc;
  logic          pc_wrap;
  logic          tc_last;

  // P and T are never zero while enabled, so P-1 / T-1 cannot underflow here
  always_comb begin
    pc_wrap = (pc == P - PW'(1));
    tc_last = (tc == T - TW'(1));
    tick    = enable & pc_wrap;
    expire  = enable & pc_wrap & tc_last;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc <= '0;
      tc <= '0;
    end else if (clear) begin
      pc <= '0;
      tc <= '0;
    end else if (enable) begin
      if (pc_wrap) begin
        pc <= '0;
        tc <= tc_last ? '0 : tc + TW'(1);
      end else begin
        pc <= pc + PW'(1);
      end
    end
  end

endmodule

// File: rtl/timer_sched.sv
// Round-robin scheduler sharing one timer_engine among NREQ requesters;
// holds the FSM, the RR arbiter and the per-grant settings latches.
module timer_sched
  import timer_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = PW_DEF,
  parameter int unsigned TW   = TW_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*PW-1:0] req_prescaler,
  input  logic [NREQ*TW-1:0] req_top,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic               busy,
  output logic               tick
);

  localparam int unsigned SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state, nstate;
  logic [SW-1:0]   ptr, nptr, sel, pick, sel_inc;
  logic [NREQ-1:0] sel_oh;
  logic            found, req_sel;
  logic [PW-1:0]   p_lat, p_new;
  logic [TW-1:0]   t_lat, t_new;
  logic            clear, enable, expire;
  int unsigned     idx;

  // Search from ptr upward with wrap; first high request wins
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = SW'(idx);
      end
    end
    p_new = req_prescaler[pick*PW +: PW];
    t_new = req_top[pick*TW +: TW];
    if (p_new == '0) p_new = PW'(1);
    if (t_new == '0) t_new = TW'(1);
  end

  always_comb begin
    req_sel = req[sel];
    sel_inc = (32'(sel) == NREQ - 1) ? '0 : sel + SW'(1);
    sel_oh  = NREQ'(1) << sel;
  end

  always_comb begin
    nstate = state;
    nptr   = ptr;
    clear  = 1'b1;
    enable = 1'b0;
    unique case (state)
      ST_IDLE: if (found) nstate = ST_LOAD;
      ST_LOAD: begin
        if (!req_sel) begin
          nstate = ST_IDLE;
          nptr   = sel_inc;
        end else begin
          nstate = ST_RUN;
        end
      end
      ST_RUN: begin
        // A dropped request cancels before the counters advance or expire
        if (!req_sel) begin
          nstate = ST_IDLE;
          nptr   = sel_inc;
        end else begin
          clear  = 1'b0;
          enable = 1'b1;
          if (expire) nstate = ST_DONE;
        end
      end
      ST_DONE: begin
        nstate = ST_IDLE;
        nptr   = sel_inc;
      end
      default: nstate = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != ST_IDLE);
    grant = busy ? sel_oh : '0;
    done  = (state == ST_DONE) ? sel_oh : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      ptr   <= '0;
      sel   <= '0;
      p_lat <= '0;
      t_lat <= '0;
    end else begin
      state <= nstate;
      ptr   <= nptr;
      if (state == ST_IDLE && found) begin
        sel   <= pick;
        p_lat <= p_new;
        t_lat <= t_new;
      end
    end
  end

  timer_engine #(
    .PW(PW),
    .TW(TW)
  ) u_engine (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear),
    .enable (enable),
    .P      (p_lat),
    .T      (t_lat),
    .tick   (tick),
    .expire (expire)
  );

endmodule

// File: doc/timer_sched.md
# timer_sched

Round-robin scheduler that shares one prescaler/top timer engine among `NREQ` requesters. Each requester asks for a delay of `prescaler × top` clock cycles. The block grants the engine to one requester at a time, loads that requester's settings, runs the count, and returns a one-cycle `done` pulse. It sits between LED/peripheral control logic and the timer datapath, so several consumers share one engine instead of instantiating a timer each.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `PW`, default 16: prescaler width.
- `TW`, default 16: top width.

- `clock` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `req` in NREQ: level request per channel. Held high for the whole delay; dropping it cancels.
- `req_prescaler` in NREQ*PW: channel i's prescaler at bits [i*PW +: PW].
- `req_top` in NREQ*TW: channel i's top at bits [i*TW +: TW].
- `grant` out NREQ: one-hot; the channel currently owning the engine.
- `done` out NREQ: one-cycle pulse on the owning channel when its delay expires.
- `busy` out 1: high in any state except IDLE.
- `tick` out 1: one-cycle pulse at each prescaler rollover while in RUN (debug/LED use).

## Operation
- All outputs reset to 0. State = IDLE, RR pointer = 0, counters = 0.
- **IDLE**
  - If any `req` is high, select the first high channel searching from the pointer upward, with wrap-around.
  - Register `sel`.
  - Latch `P = max(req_prescaler[sel], 1)` and `T = max(req_top[sel], 1)`; zero is treated as 1.
  - Go to LOAD.
- **LOAD** (1 cycle)
  - `grant[sel]` = 1.
  - Prescale counter `pc` = 0, top counter `tc` = 0.
  - Go to RUN.
- **RUN**
  - `pc` increments each cycle.
  - When `pc == P-1`: `pc` wraps to 0, `tick` = 1, and `tc` increments.
  - When `pc == P-1` and `tc == T-1`: go to DONE.
- **DONE** (1 cycle)
  - `done[sel]` = 1 and `grant[sel]` stays 1.
  - Pointer = `sel+1` modulo NREQ.
  - Go to IDLE.
- **Cancel:** in LOAD or RUN, if `req[sel]` is sampled low:
  - Go to IDLE next cycle; no `done`.
  - Pointer = `sel+1`.
  - Counters are cleared.
- Settings are latched in IDLE only. Changes to `req_prescaler`/`req_top` during RUN have no effect.
- Requests from other channels during LOAD, RUN or DONE wait; they are never lost while held.
- A channel that keeps `req` high after `done` re-enters arbitration. If it is the only requester, it repeats with period P·T+3.
- `grant` is 0 in IDLE.

## Timing
- Request seen at edge k (IDLE):
  - LOAD during cycle k+1.
  - RUN during cycles k+2 .. k+1+P·T.
  - `done` high during cycle k+2+P·T.
  - IDLE again at cycle k+3+P·T.
- Overhead is 3 cycles (IDLE, LOAD, DONE) per granted delay.
- `grant` spans LOAD through DONE: P·T+2 cycles.
- Counter widths:
  - `pc` is PW bits; `tc` is TW bits.
  - The comparisons never overflow, because `pc ≤ P-1` and `tc ≤ T-1`.
- Maximum delay: (2^PW−1)(2^TW−1) cycles.
- Asserting `reset` mid-RUN:
  - All outputs drop asynchronously; no `done` is emitted.
  - After release, state = IDLE and pointer = 0.
- Simultaneous requests are resolved by the RR pointer only. There is no fixed priority beyond search order.

## Structure
- Shared package `timer_pkg`:
  - State encoding constants `ST_IDLE = 2'd0`, `ST_LOAD = 2'd1`, `ST_RUN = 2'd2`, `ST_DONE = 2'd3`.
  - Default widths `PW_DEF = 16`, `TW_DEF = 16`.
- One sub-module `timer_engine`:
  - Holds the `pc`/`tc` counters.
  - Inputs: `clear`, `enable`, `P`, `T`.
  - Outputs: `tick`, `expire`.
  - `expire` is combinational on `pc == P-1 && tc == T-1 && enable`.
- The top level holds the FSM, the RR arbiter and the settings latches.

## Test plan
- Single channel, `req[0]` = 1, P = 3, T = 4 → `grant[0]` high 14 cycles; `done[0]` pulse exactly 14 cycles after `req` is sampled (k+2+12); 4 `tick` pulses.
- Zero settings, P = 0, T = 0 on channel 1 → treated as 1×1; `done[1]` at k+3; `grant` 3 cycles.
- All four `req` high together, P = 2, T = 2 → grants in order 0, 1, 2, 3, 0…; each `done` 7 cycles apart; no channel starved.
- Cancel: channel 2 with P = 10, T = 10; drop `req[2]` after 20 RUN cycles → no `done[2]`; `busy` low next cycle; pointer = 3, so a pending `req[0]` and `req[3]` resolve to channel 3.
- Reset mid-RUN: assert `reset` low asynchronously between edges → `grant`, `busy`, `tick`, `done` go 0 immediately; after release with `req[1]` high, channel 1 is granted (pointer = 0, search finds 1).
- Setting change during RUN: alter `req_top[0]` from 4 to 9 mid-count → `done[0]` timing still matches T = 4.
